// File: rtl/resv_station_add.sv
// resv_station_add: reservation station feeding the FP add/sub unit.
// Holds issued operations until both operands are available (directly or
// captured from the CDB), dispatches one ready entry per cycle, and frees an
// entry when the CDB broadcasts that entry's own tag.
// Optional build macro: RS_AGE_ORDER_EN -- dispatch the oldest ready entry
// instead of the lowest-index ready entry.
module resv_station_add #(
    parameter int ENTRIES  = 3,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3,
    parameter int BASE_TAG = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              issue_valid,
    input  logic [1:0]        issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              fu_ready,
    output logic              exec_valid,
    output logic [DATA_W-1:0] resv_out1,
    output logic [DATA_W-1:0] resv_out2,
    output logic [1:0]        OP,
    output logic [TAG_W-1:0]  exec_tag,
    output logic              full
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Per-entry state
    logic [ENTRIES-1:0] r_busy;
    logic [ENTRIES-1:0] r_disp;
    logic [1:0]         r_op [ENTRIES];
    logic [DATA_W-1:0]  r_vj [ENTRIES];
    logic [DATA_W-1:0]  r_vk [ENTRIES];
    logic [TAG_W-1:0]   r_qj [ENTRIES];
    logic [TAG_W-1:0]   r_qk [ENTRIES];

    // Allocation
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [TAG_W-1:0]   w_free_tag;
    logic               w_issue_acc;

    // Issue fields after CDB bypass and op normalisation
    logic [1:0]         w_new_op;
    logic [DATA_W-1:0]  w_new_vj;
    logic [TAG_W-1:0]   w_new_qj;
    logic [DATA_W-1:0]  w_new_vk;
    logic [TAG_W-1:0]   w_new_qk;

    // Dispatch selection
    logic [ENTRIES-1:0] w_ready;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [DATA_W-1:0]  w_sel_vj;
    logic [DATA_W-1:0]  w_sel_vk;
    logic [1:0]         w_sel_op;
    logic [TAG_W-1:0]   w_sel_tag;
    logic               w_dispatch;

    // Free on own-tag broadcast
    logic [ENTRIES-1:0] w_free_hit;

    function automatic logic [TAG_W-1:0] entry_tag(input int unsigned idx);
        return TAG_W'(32'(BASE_TAG) + idx);
    endfunction

`ifdef RS_AGE_ORDER_EN
    localparam int AGE_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Age 0 is the youngest busy entry; larger means issued earlier.
    logic [AGE_W-1:0]   r_age [ENTRIES];
    logic [AGE_W-1:0]   w_sel_age;
    logic               w_free_any;
    logic [AGE_W-1:0]   w_free_age;
`endif

    assign issue_ready = w_free_found;
    assign full        = ~w_free_found;
    assign issue_tag   = w_free_tag;
    assign w_issue_acc = issue_valid && w_free_found;
    assign w_dispatch  = fu_ready && w_sel_found;

    // Lowest-index non-busy entry, from registered state only
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_free_tag   = entry_tag(0);
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!r_busy[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
                w_free_tag   = entry_tag(i);
            end
        end
    end

    // Issue-time operand bypass from a concurrent CDB broadcast
    always_comb begin
        w_new_op = (issue_op == 2'd2) ? 2'd2 : 2'd1;
        w_new_vj = issue_vj;
        w_new_qj = issue_qj;
        w_new_vk = issue_vk;
        w_new_qk = issue_qk;
        if (cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag)) begin
            w_new_vj = cdb_data;
            w_new_qj = '0;
        end
        if (cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag)) begin
            w_new_vk = cdb_data;
            w_new_qk = '0;
        end
    end

    // Ready and own-tag free detection per entry
    always_comb begin
        w_ready    = '0;
        w_free_hit = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            w_ready[i]    = r_busy[i] && !r_disp[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
            w_free_hit[i] = cdb_valid && r_busy[i] && (cdb_tag == entry_tag(i));
        end
    end

`ifdef RS_AGE_ORDER_EN
    // Age of the entry being freed this cycle (at most one: a single CDB tag)
    always_comb begin
        w_free_any = 1'b0;
        w_free_age = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (w_free_hit[i]) begin
                w_free_any = 1'b1;
                w_free_age = r_age[i];
            end
        end
    end

    // Oldest ready entry wins; busy entries have distinct ages
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        w_sel_vj    = '0;
        w_sel_vk    = '0;
        w_sel_op    = '0;
        w_sel_tag   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (w_ready[i] && (!w_sel_found || (r_age[i] > w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = r_age[i];
                w_sel_vj    = r_vj[i];
                w_sel_vk    = r_vk[i];
                w_sel_op    = r_op[i];
                w_sel_tag   = entry_tag(i);
            end
        end
    end

    // Age bookkeeping: new entry is youngest, others age on issue and close gaps on free
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (w_issue_acc && (w_free_idx == IDX_W'(i))) begin
                    r_age[i] <= '0;
                end else if (r_busy[i]) begin
                    if (w_issue_acc && !(w_free_any && (r_age[i] > w_free_age))) begin
                        r_age[i] <= r_age[i] + AGE_W'(1);
                    end else if (!w_issue_acc && w_free_any && (r_age[i] > w_free_age)) begin
                        r_age[i] <= r_age[i] - AGE_W'(1);
                    end
                end
            end
        end
    end
`else
    // Lowest-index ready entry wins
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_vj    = '0;
        w_sel_vk    = '0;
        w_sel_op    = '0;
        w_sel_tag   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (w_ready[i] && !w_sel_found) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_vj    = r_vj[i];
                w_sel_vk    = r_vk[i];
                w_sel_op    = r_op[i];
                w_sel_tag   = entry_tag(i);
            end
        end
    end
`endif

    // Entry update: allocate, capture, mark dispatched, free (free overrides dispatch)
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_busy <= '0;
            r_disp <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_op[i] <= '0;
                r_vj[i] <= '0;
                r_vk[i] <= '0;
                r_qj[i] <= '0;
                r_qk[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (w_issue_acc && (w_free_idx == IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_disp[i] <= 1'b0;
                    r_op[i]   <= w_new_op;
                    r_vj[i]   <= w_new_vj;
                    r_qj[i]   <= w_new_qj;
                    r_vk[i]   <= w_new_vk;
                    r_qk[i]   <= w_new_qk;
                end else begin
                    if (cdb_valid && r_busy[i] && (cdb_tag != '0)) begin
                        if (r_qj[i] == cdb_tag) begin
                            r_vj[i] <= cdb_data;
                            r_qj[i] <= '0;
                        end
                        if (r_qk[i] == cdb_tag) begin
                            r_vk[i] <= cdb_data;
                            r_qk[i] <= '0;
                        end
                    end
                    if (w_dispatch && (w_sel_idx == IDX_W'(i))) begin
                        r_disp[i] <= 1'b1;
                    end
                    if (w_free_hit[i]) begin
                        r_busy[i] <= 1'b0;
                        r_disp[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Registered dispatch outputs; data holds when nothing is dispatched
    always_ff @(posedge Clock) begin
        if (Reset) begin
            exec_valid <= 1'b0;
            resv_out1  <= '0;
            resv_out2  <= '0;
            OP         <= '0;
            exec_tag   <= '0;
        end else if (w_dispatch) begin
            exec_valid <= 1'b1;
            resv_out1  <= w_sel_vj;
            resv_out2  <= w_sel_vk;
            OP         <= w_sel_op;
            exec_tag   <= w_sel_tag;
        end else begin
            exec_valid <= 1'b0;
        end
    end

endmodule

// File: doc/resv_station_add.md
Name: resv_station_add

Overview:
- Reservation station for the FP add/sub unit in the Tomasulo core; sits directly upstream of the FP adder.
- Accepts issued instructions, holds operands or producer tags, and snoops the CDB for missing operands.
- Dispatches one ready entry per cycle to the adder as resv_out1/resv_out2/OP.
- Frees an entry when the CDB broadcasts that entry's own tag.

Parameters:
ENTRIES, 3, number of station entries
DATA_W, 16, operand and CDB data width
TAG_W, 3, tag width; tag 0 means "operand valid, no producer"
BASE_TAG, 1, tag of entry 0; entry i has tag BASE_TAG+i, so BASE_TAG+ENTRIES-1 must be < 2^TAG_W

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
issue_valid  in  1  issue request this cycle
issue_op  in  2  1=add, 2=sub; 0 and 3 are reserved and treated as add
issue_vj  in  DATA_W  operand j value, used when issue_qj==0
issue_qj  in  TAG_W  producer tag of j; 0 means valid
issue_vk  in  DATA_W  operand k value
issue_qk  in  TAG_W  producer tag of k
issue_ready  out  1  at least one free entry (combinational from registered state)
issue_tag  out  TAG_W  tag the next accepted issue will receive
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB producer tag
cdb_data  in  DATA_W  CDB value
fu_ready  in  1  adder can accept an operation this cycle
exec_valid  out  1  one-cycle pulse: operands on resv_out1/2 valid
resv_out1  out  DATA_W  operand j to adder
resv_out2  out  DATA_W  operand k to adder
OP  out  2  operation to adder
exec_tag  out  TAG_W  tag of the dispatched entry
full  out  1  all entries busy (equals !issue_ready)

Behaviour:
- Per-entry state: busy, dispatched, op, vj, qj, vk, qk.
- Reset: all entries cleared (busy=0, dispatched=0, qj=qk=0). exec_valid=0, resv_out1=resv_out2=0, OP=0, exec_tag=0; hence issue_ready=1, full=0, issue_tag=BASE_TAG.
- Issue:
  - Accepted when issue_valid && issue_ready.
  - Allocates the lowest-index non-busy entry, as seen in registered state; issue_tag reports that entry's tag.
  - issue_valid while !issue_ready is ignored, with no state change.
- CDB capture:
  - On cdb_valid, every busy entry with qj==cdb_tag (cdb_tag≠0) loads vj=cdb_data and sets qj=0; same for k.
  - Issue bypass: if an issue is accepted while cdb_valid and issue_qj==cdb_tag≠0, the entry is written with vj=cdb_data, qj=0; same for k. This prevents a lost wakeup.
- Free:
  - On cdb_valid with cdb_tag equal to a busy entry's own tag, that entry's busy and dispatched clear.
  - A freed entry is not reallocatable in the same cycle, since issue_ready derives from pre-edge state.
- Dispatch:
  - Ready = busy && !dispatched && qj==0 && qk==0, evaluated on registered state.
  - Operands captured from the CDB this cycle are ready next cycle.
  - When fu_ready and any entry is ready, the lowest-index ready entry is selected. At the next edge: exec_valid=1, resv_out1=vj, resv_out2=vk, OP=op, exec_tag=its tag, and that entry's dispatched bit is set.
  - Otherwise exec_valid=0 and the data outputs hold their previous values.
- Latency: an issue with both operands valid in cycle N gives exec_valid in cycle N+2. At most one dispatch per cycle.
- A CDB broadcast of a tag for a not-busy entry, or a tag outside the station's range, only performs operand capture.
- Issue, capture, free and dispatch may all occur in the same cycle on different entries without interference.
- Reset asserted mid-operation discards all entries and any pending dispatch on the next edge.

Optional Feature:
RS_AGE_ORDER_EN:
- Defined: each entry holds an age counter of clog2(ENTRIES) bits. Dispatch selects the oldest ready entry (earliest issued); ties are impossible. Ages are updated on issue and free.
- Undefined: lowest-index ready entry wins, as above.

Test Plan:
- Reset, then issue add vj=0x0003 qj=0, vk=0x0004 qk=0, with fu_ready=1 -> issue_tag=1; exec_valid two cycles later with resv_out1=0x0003, resv_out2=0x0004, OP=1, exec_tag=1.
- Issue sub with qj=5, vk=0x0010; three cycles later, CDB tag 5 with data 0x0020 -> dispatch the following cycle with resv_out1=0x0020, resv_out2=0x0010, OP=2.
- Issue with qk=4 in the same cycle as CDB tag 4 carrying data 0x00AA -> bypass captured; entry dispatches with resv_out2=0x00AA without waiting for any further broadcast.
- Fill all 3 entries -> full=1, issue_ready=0; a 4th issue_valid is ignored. CDB tag 2 -> next cycle issue_ready=1, issue_tag=2.
- Hold fu_ready=0 with two ready entries -> exec_valid stays 0. Raise fu_ready -> two consecutive pulses, exec_tag 1 then 2 (lowest index first). With RS_AGE_ORDER_EN, and entry 2 issued before entry 1, the order is 2 then 1.
- Assert Reset while an entry is waiting on a tag -> all outputs return to reset values; a later CDB broadcast of that tag causes no dispatch.
